// File: rtl/comm_dac_modulator.sv
// Manchester frame transmitter: A5 preamble, 32-bit response MSB first, even parity, then a guard interval.
// Outputs are registered and follow acceptance by one cycle; inputs are ignored outside IDLE.
module comm_dac_modulator #(
  parameter int          BIT_TICKS   = 20,
  parameter int          GUARD_TICKS = 40,
  parameter logic [7:0]  START_BYTE  = 8'hA5,
  parameter logic [11:0] DAC_HIGH    = 12'hC00,
  parameter logic [11:0] DAC_LOW     = 12'h400,
  parameter logic [11:0] DAC_IDLE    = 12'h800
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        transmitter_on,
  input  logic [31:0] rspns,
  output logic        rspns_read,
  output logic [11:0] com_dac,
  output logic        comm_dac_on
);

  localparam int MAX_TICKS = (BIT_TICKS > GUARD_TICKS) ? BIT_TICKS : GUARD_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_TICKS - 1);
  localparam logic [TW-1:0] HALF       = TW'(BIT_TICKS / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, GUARD} state_t;

  state_t        state_q, state_n;
  logic [TW-1:0] tick_q, tick_n;
  logic [5:0]    bit_q, bit_n;
  logic [5:0]    bit_last;
  logic [31:0]   word_q;
  logic          parity_q;
  logic          accept;
  logic          line_bit;
  logic [11:0]   com_dac_n;

  always_comb begin
    state_n  = state_q;
    tick_n   = tick_q;
    bit_n    = bit_q;
    accept   = 1'b0;
    bit_last = (state_q == START) ? 6'd7 : (state_q == DATA) ? 6'd31 : 6'd0;
    case (state_q)
      IDLE: begin
        if (transmitter_on) begin
          accept  = 1'b1;
          state_n = START;
          tick_n  = '0;
          bit_n   = '0;
        end
      end
      START, DATA, PARITY: begin
        if (tick_q == BIT_LAST) begin
          tick_n = '0;
          if (bit_q == bit_last) begin
            bit_n = '0;
            if (state_q == START)     state_n = DATA;
            else if (state_q == DATA) state_n = PARITY;
            else                      state_n = GUARD;
          end else begin
            bit_n = bit_q + 6'd1;
          end
        end else begin
          tick_n = tick_q + 1'b1;
        end
      end
      GUARD: begin
        if (tick_q == GUARD_LAST) begin
          tick_n  = '0;
          state_n = IDLE;
        end else begin
          tick_n = tick_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output codes are derived from the next-cycle position so the line is registered yet aligned.
  always_comb begin
    line_bit = 1'b0;
    case (state_n)
      START:   line_bit = START_BYTE[3'd7 - bit_n[2:0]];
      DATA:    line_bit = word_q[5'd31 - bit_n[4:0]];
      PARITY:  line_bit = parity_q;
      default: line_bit = 1'b0;
    endcase
    if (state_n == IDLE || state_n == GUARD)
      com_dac_n = DAC_IDLE;
    else
      com_dac_n = ((tick_n < HALF) == line_bit) ? DAC_HIGH : DAC_LOW;
  end

  always_ff @(posedge inclk) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      parity_q    <= 1'b0;
      rspns_read  <= 1'b0;
      com_dac     <= DAC_IDLE;
      comm_dac_on <= 1'b0;
    end else begin
      state_q     <= state_n;
      tick_q      <= tick_n;
      bit_q       <= bit_n;
      if (accept) begin
        word_q   <= rspns;
        parity_q <= ^rspns;
      end
      rspns_read  <= accept;
      com_dac     <= com_dac_n;
      comm_dac_on <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_comm_dac_modulator.sv
// Directed bench for comm_dac_modulator with BIT_TICKS=4, GUARD_TICKS=8 (frame = 172 cycles).
module tb_comm_dac_modulator;

  logic        inclk = 1'b0;
  logic        reset;
  logic        transmitter_on;
  logic [31:0] rspns;
  logic        rspns_read;
  logic [11:0] com_dac;
  logic        comm_dac_on;

  int total = 0;
  int bad   = 0;

  logic [11:0] last_codes [0:255];
  int          last_len;

  always #5 inclk = ~inclk;

  comm_dac_modulator #(.BIT_TICKS(4), .GUARD_TICKS(8)) dut (
    .inclk          (inclk),
    .reset          (reset),
    .transmitter_on (transmitter_on),
    .rspns          (rspns),
    .rspns_read     (rspns_read),
    .com_dac        (com_dac),
    .comm_dac_on    (comm_dac_on)
  );

  // Expected line code at frame cycle i: A5 preamble, word MSB first, even parity, guard.
  function automatic logic [11:0] exp_code(input logic [31:0] w, input int i);
    logic [7:0] sb;
    logic       bv;
    int         b;
    int         t;
    sb = 8'hA5;
    b  = i / 4;
    t  = i % 4;
    if (i >= 164) return 12'h800;
    if (b < 8)       bv = sb[7-b];
    else if (b < 40) bv = w[39-b];
    else             bv = ^w;
    return ((t < 2) == bv) ? 12'hC00 : 12'h400;
  endfunction

  // Called right after the negedge at which a frame request becomes visible to the DUT.
  task automatic capture_frame(input logic [31:0] word, input int alt_at,
                               input logic [31:0] alt_word, input string name);
    int len = 0, reads = 0, read_idx = -1, guard = 0, errs = 0, first_err = -1;
    do begin
      @(negedge inclk);
      guard++;
      transmitter_on = 1'b0;
      if (len == alt_at) rspns = alt_word;
      if (rspns_read) begin
        reads++;
        if (read_idx < 0) read_idx = len;
      end
      if (comm_dac_on) begin
        if (len < 256) last_codes[len] = com_dac;
        len++;
      end
    end while (!(len > 0 && !comm_dac_on) && guard < 400);
    last_len = len;
    total++;
    if (guard >= 400) begin
      bad++; $display("FAIL %s timeout: frame did not end, len=%0d required 172", name, len);
    end
    total++;
    if (len !== 172) begin
      bad++; $display("FAIL %s length: comm_dac_on high %0d cycles, required 172", name, len);
    end
    total++;
    if (reads !== 1 || read_idx !== 0) begin
      bad++; $display("FAIL %s rspns_read: %0d pulses at frame cycle %0d, required 1 at 0", name, reads, read_idx);
    end
    for (int i = 0; i < 172 && i < len; i++)
      if (last_codes[i] !== exp_code(word, i)) begin
        errs++;
        if (first_err < 0) first_err = i;
      end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s codes: %0d wrong, first at cycle %0d got %h required %h",
               name, errs, first_err, last_codes[first_err], exp_code(word, first_err));
    end
  endtask

  task automatic test_reset();
    int errs = 0;
    reset = 1'b1; transmitter_on = 1'b0; rspns = 32'h0;
    repeat (3) @(negedge inclk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge inclk);
      if (com_dac !== 12'h800 || comm_dac_on !== 1'b0 || rspns_read !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL reset_idle: %0d bad cycles, last dac=%h on=%b rd=%b required 800/0/0",
                      errs, com_dac, comm_dac_on, rspns_read);
    end
  endtask

  task automatic test_single_frame();
    rspns = 32'h8000_0001; transmitter_on = 1'b1;
    capture_frame(32'h8000_0001, -1, 32'h0, "single");
    total++;
    if ({last_codes[0], last_codes[1], last_codes[2], last_codes[3],
         last_codes[4], last_codes[5], last_codes[6], last_codes[7]} !==
        {12'hC00, 12'hC00, 12'h400, 12'h400, 12'h400, 12'h400, 12'hC00, 12'hC00}) begin
      bad++; $display("FAIL start_bits: got %h %h %h %h %h %h %h %h required C00 C00 400 400 400 400 C00 C00",
                      last_codes[0], last_codes[1], last_codes[2], last_codes[3],
                      last_codes[4], last_codes[5], last_codes[6], last_codes[7]);
    end
    total++;
    if ({last_codes[32], last_codes[33], last_codes[34], last_codes[35]} !==
        {12'hC00, 12'hC00, 12'h400, 12'h400}) begin
      bad++; $display("FAIL first_data_bit: got %h %h %h %h required C00 C00 400 400",
                      last_codes[32], last_codes[33], last_codes[34], last_codes[35]);
    end
    total++;
    if ({last_codes[160], last_codes[161], last_codes[162], last_codes[163]} !==
        {12'h400, 12'h400, 12'hC00, 12'hC00}) begin
      bad++; $display("FAIL parity0: got %h %h %h %h required 400 400 C00 C00",
                      last_codes[160], last_codes[161], last_codes[162], last_codes[163]);
    end
    total++;
    if (com_dac !== 12'h800 || rspns_read !== 1'b0) begin
      bad++; $display("FAIL after_frame: dac=%h rd=%b required 800/0", com_dac, rspns_read);
    end
    repeat (2) @(negedge inclk);
  endtask

  task automatic test_parity();
    int errs = 0;
    rspns = 32'h0000_0001; transmitter_on = 1'b1;
    capture_frame(32'h0000_0001, -1, 32'h0, "parity1");
    total++;
    if ({last_codes[160], last_codes[161], last_codes[162], last_codes[163]} !==
        {12'hC00, 12'hC00, 12'h400, 12'h400}) begin
      bad++; $display("FAIL parity1_bit: got %h %h %h %h required C00 C00 400 400",
                      last_codes[160], last_codes[161], last_codes[162], last_codes[163]);
    end
    repeat (2) @(negedge inclk);
    rspns = 32'h0; transmitter_on = 1'b1;
    capture_frame(32'h0, -1, 32'h0, "zero_word");
    for (int i = 32; i < 160; i++)
      if (last_codes[i] !== (((i % 4) < 2) ? 12'h400 : 12'hC00)) errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL zero_data: %0d data cycles not L,L,H,H, required 0", errs);
    end
    repeat (2) @(negedge inclk);
  endtask

  task automatic test_back_to_back();
    int cyc = 0, reads = 0, r1 = -1, r2 = -1, low = 0;
    rspns = 32'h1234_5678; transmitter_on = 1'b1;
    while (cyc < 500 && !(r2 >= 0 && !comm_dac_on)) begin
      @(negedge inclk);
      cyc++;
      if (rspns_read) begin
        reads++;
        if (r1 < 0) begin
          r1 = cyc; rspns = 32'hCAFE_0F0F;
        end else begin
          r2 = cyc; transmitter_on = 1'b0;
        end
      end else if (r1 >= 0 && r2 < 0 && !comm_dac_on) begin
        low++;
      end
    end
    repeat (10) begin
      @(negedge inclk);
      if (rspns_read) reads++;
    end
    total++;
    if (cyc >= 500) begin
      bad++; $display("FAIL b2b_timeout: second frame not seen in %0d cycles", cyc);
    end
    total++;
    if (reads !== 2) begin
      bad++; $display("FAIL b2b_reads: got %0d pulses required 2", reads);
    end
    total++;
    if (r2 - r1 !== 173) begin
      bad++; $display("FAIL b2b_gap: pulses %0d cycles apart required 173", r2 - r1);
    end
    total++;
    if (low !== 1) begin
      bad++; $display("FAIL b2b_low: comm_dac_on low %0d cycles between frames required 1", low);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0, guard = 0;
    rspns = 32'h5555_AAAA; transmitter_on = 1'b1;
    while (n < 50 && guard < 300) begin
      @(negedge inclk);
      guard++;
      transmitter_on = 1'b0;
      if (comm_dac_on) n++;
    end
    reset = 1'b1; transmitter_on = 1'b1; rspns = 32'h3C3C_C3C3;
    @(negedge inclk);
    total++;
    if (com_dac !== 12'h800 || comm_dac_on !== 1'b0 || rspns_read !== 1'b0) begin
      bad++; $display("FAIL midreset_abort: dac=%h on=%b rd=%b required 800/0/0",
                      com_dac, comm_dac_on, rspns_read);
    end
    @(negedge inclk);
    total++;
    if (comm_dac_on !== 1'b0 || rspns_read !== 1'b0) begin
      bad++; $display("FAIL midreset_priority: on=%b rd=%b required 0/0 while reset held",
                      comm_dac_on, rspns_read);
    end
    reset = 1'b0;
    capture_frame(32'h3C3C_C3C3, -1, 32'h0, "post_reset");
    repeat (2) @(negedge inclk);
  endtask

  task automatic test_input_change();
    rspns = 32'hF0F0_A5A5; transmitter_on = 1'b1;
    capture_frame(32'hF0F0_A5A5, 60, 32'h0F0F_5A5A, "rspns_change");
    repeat (2) @(negedge inclk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_input_change();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
